wb_burst_reader: RTL and testbench
==================================

// Module: wb_burst_reader
// PURPOSE
//  Wishbone master: fetches a block of 32-bit words from a Wishbone slave
//  (e.g. the BlockRAM/SDRAM controller) using incrementing bursts.
//  Words are buffered in an internal FIFO and delivered on a valid/ready stream.
//  Serves as the read engine for the display/DMA path.
// PARAMETERS
//  BURST_LEN   8   max beats per burst; power of 2, 1..FIFO_DEPTH
//  FIFO_DEPTH  16  output FIFO depth in words; power of 2
//  LEN_WIDTH   16  width of the word-count request
// PORTS
//  clk        in   1          clock; must equal wb_m.clk
//  rst        in   1          synchronous active-high reset; must equal wb_m.rst
//  wb_m       -    wshb_if    master modport: drives cyc,stb,we,sel,adr,cti,bte; samples ack,dat_sm
//  start      in   1          request pulse, accepted only when busy=0
//  base_adr   in   32         byte start address; bits[1:0] ignored (forced 00)
//  nwords     in   LEN_WIDTH  number of 32-bit words to read
//  busy       out  1          request in progress
//  done       out  1          one-cycle pulse: last word of the request accepted from bus
//  out_data   out  32         FIFO head word
//  out_valid  out  1          FIFO not empty
//  out_ready  in   1          consumer pops when out_valid&&out_ready
// BEHAVIOUR
//  Reset: cyc=stb=we=0, sel=4'hF, cti=3'b000, bte=2'b00, adr=0, busy=0, done=0,
//   FIFO flushed (out_valid=0). Reset mid-burst: cyc/stb low from next edge; request dropped.
//  we=0 and sel=4'hF at all times; bte=00 (linear). All bus outputs registered.
//  FSM IDLE -> CHECK -> BURST -> CHECK ... -> IDLE.
//  IDLE: start=1 latches base_adr (word aligned) and nwords into rem, busy=1 -> CHECK.
//   nwords=0: done=1 for one cycle, busy stays 0, no bus activity.
//   start while busy=1 is ignored.
//  CHECK: chunk=min(BURST_LEN,rem); if FIFO free slots (including slots freed
//   by a pop this cycle) >= chunk -> BURST. Else stay in CHECK with cyc=0.
//  BURST: cyc=stb=1; cti=3'b010 on every beat except the last of the chunk, 3'b111 on the last
//   (a 1-beat chunk uses 111 directly). A beat completes on a cycle with ack=1:
//   dat_sm pushed to FIFO, adr+=4 (wraps mod 2^32), rem-=1, next beat presented
//   next cycle. ack=0: adr/cti/stb held stable (wait state).
//   Throughput with ack held high: 1 word/cycle.
//  After the ack on the 111 beat: cyc=stb=0, cti=000 for >=1 cycle; rem=0 ->
//   done=1 same cycle, busy=0, IDLE; else -> CHECK.
//  ack while cyc=0 is ignored.
//  FIFO: space is reserved before each burst, so overflow cannot occur.
//   Simultaneous push and pop: count unchanged. Pop when empty: no effect.
//   out_data valid the same cycle out_valid=1 (first-word fall-through).
//   Data order equals address order.
//  done may fire while words remain in the FIFO; the FIFO drains after done.
// TESTING
//  1. BURST_LEN=8, base 0x100, nwords=4, ack=stb, out_ready=1
//     -> adr 0x100,0x104,0x108,0x10C; cti 010,010,010,111; 4 words out in order; done once.
//  2. nwords=20 -> bursts of 8,8,4 beats; cyc low >=1 cycle between bursts;
//     last adr = base+0x4C; done after 20th ack.
//  3. FIFO_DEPTH=16, out_ready=0, nwords=40 -> exactly 16 acks, then cyc stays 0;
//     raise out_ready -> fetching resumes; all 40 words delivered in order.
//  4. Slave inserts 2 wait cycles (ack=0) on beat 3 -> adr/cti/stb stable during wait;
//     no duplicate or lost word.
//  5. nwords=0 -> done pulse, cyc never asserted. start pulsed mid-request -> ignored,
//     word count unchanged.
//  6. rst=1 during beat 5 of an 8-beat burst -> next cycle cyc=stb=0, busy=0,
//     out_valid=0; a new start afterwards completes normally.

Source files
------------

// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 bus bundle shared by the burst reader and its slave.
// Ports: clk, rst; master/slave modports split the signal directions.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic [31:0] dat_sm;

  modport master (
    input  clk, rst, ack, dat_sm,
    output cyc, stb, we, sel, adr, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, cti, bte,
    output ack, dat_sm
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone burst read engine: fetches nwords words from base_adr into a
// FWFT FIFO, streamed out on out_data/out_valid/out_ready.
// Ports: clk, rst (sync, high), wb_m (master), start/base_adr/nwords request,
// busy/done status, out_data/out_valid/out_ready stream.
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  wshb_if.master               wb_m,
  input  logic                 start,
  input  logic [31:0]          base_adr,
  input  logic [LEN_WIDTH-1:0] nwords,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    BURST
  } state_t;

  state_t               state, state_n;
  logic [31:0]          adr, adr_n;
  logic [LEN_WIDTH-1:0] rem, rem_n;
  logic [CW-1:0]        beats, beats_n;
  logic                 cyc, cyc_n;
  logic [2:0]           cti, cti_n;
  logic                 busy_n, done_n;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [CW-1:0] chunk, free;

  assign wb_m.cyc = cyc;
  assign wb_m.stb = cyc;
  assign wb_m.we  = 1'b0;
  assign wb_m.sel = 4'hF;
  assign wb_m.adr = adr;
  assign wb_m.cti = cti;
  assign wb_m.bte = 2'b00;

  assign push      = (state == BURST) && cyc && wb_m.ack;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // A pop this cycle frees its slot before the next burst can push.
  assign free = CW'(FIFO_DEPTH) - count + CW'(pop);

  always_comb begin
    chunk = CW'(BURST_LEN);
    if (rem < LEN_WIDTH'(BURST_LEN))
      chunk = CW'(rem);
  end

  always_comb begin
    state_n = state;
    adr_n   = adr;
    rem_n   = rem;
    beats_n = beats;
    cyc_n   = cyc;
    cti_n   = cti;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (nwords == '0) begin
            done_n = 1'b1;
          end else begin
            adr_n   = {base_adr[31:2], 2'b00};
            rem_n   = nwords;
            busy_n  = 1'b1;
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        if (free >= chunk) begin
          state_n = BURST;
          cyc_n   = 1'b1;
          beats_n = chunk;
          cti_n   = (chunk == CW'(1)) ? 3'b111 : 3'b010;
        end
      end
      BURST: begin
        if (push) begin
          adr_n   = adr + 32'd4;
          rem_n   = rem - LEN_WIDTH'(1);
          beats_n = beats - CW'(1);
          if (beats == CW'(1)) begin
            cyc_n = 1'b0;
            cti_n = 3'b000;
            if (rem == LEN_WIDTH'(1)) begin
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = IDLE;
            end else begin
              state_n = CHECK;
            end
          end else begin
            cti_n = (beats == CW'(2)) ? 3'b111 : 3'b010;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      adr   <= '0;
      rem   <= '0;
      beats <= '0;
      cyc   <= 1'b0;
      cti   <= 3'b000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      adr   <= adr_n;
      rem   <= rem_n;
      beats <= beats_n;
      cyc   <= cyc_n;
      cti   <= cti_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wb_m.dat_sm;
  end
endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader with a zero/low-wait slave model.
// Ports: none; drives the DUT and a wshb_if instance.
module tb_wb_burst_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] nwords;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ack_en;

  wshb_if bus (.clk(clk), .rst(rst));

  assign bus.ack    = bus.cyc && bus.stb && ack_en;
  assign bus.dat_sm = bus.adr ^ 32'hCAFE_0000;

  wb_burst_reader #(
    .BURST_LEN (8),
    .FIFO_DEPTH(16),
    .LEN_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_m     (bus),
    .start    (start),
    .base_adr (base_adr),
    .nwords   (nwords),
    .busy     (busy),
    .done     (done),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  logic [31:0] adr_q[$];
  logic [2:0]  cti_q[$];
  logic [31:0] out_q[$];
  int          burst_q[$];
  int          done_cnt = 0;
  int          cyc_rise = 0;
  int          cur_len  = 0;
  logic        cyc_d    = 1'b0;

  always @(negedge clk) begin
    #1;
    if (bus.cyc && !cyc_d) begin
      cyc_rise++;
      cur_len = 0;
    end
    if (bus.cyc && bus.stb && bus.ack) begin
      adr_q.push_back(bus.adr);
      cti_q.push_back(bus.cti);
      cur_len++;
    end
    if (!bus.cyc && cyc_d)
      burst_q.push_back(cur_len);
    if (out_valid && out_ready)
      out_q.push_back(out_data);
    if (done)
      done_cnt++;
    cyc_d = bus.cyc;
  end

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    @(negedge clk);
    base_adr = b;
    nwords   = n;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_adr = '0; nwords = '0;
    out_ready = 1'b0; ack_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++; if (bus.cyc !== 1'b0) begin errs++; $display("FAIL reset_cyc got %b want 0", bus.cyc); end
    vec++; if (bus.stb !== 1'b0) begin errs++; $display("FAIL reset_stb got %b want 0", bus.stb); end
    vec++; if (bus.we !== 1'b0) begin errs++; $display("FAIL reset_we got %b want 0", bus.we); end
    vec++; if (bus.sel !== 4'hF) begin errs++; $display("FAIL reset_sel got %h want f", bus.sel); end
    vec++; if (bus.cti !== 3'b000) begin errs++; $display("FAIL reset_cti got %b want 000", bus.cti); end
    vec++; if (bus.bte !== 2'b00) begin errs++; $display("FAIL reset_bte got %b want 00", bus.bte); end
    vec++; if (bus.adr !== 32'h0) begin errs++; $display("FAIL reset_adr got %h want 0", bus.adr); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", out_valid); end
  endtask

  task automatic test_basic;
    int a0, o0, d0, bad;
    bit to;
    logic [31:0] ga, gd;
    logic [2:0] gc;
    out_ready = 1'b1; ack_en = 1'b1;
    a0 = adr_q.size(); o0 = out_q.size(); d0 = done_cnt;
    do_start(32'h0000_0103, 16'd4);
    wait_idle(100, to);
    repeat (4) @(negedge clk);
    vec++; if (to) begin errs++; $display("FAIL basic_timeout busy still 1 want 0"); end
    vec++; if (adr_q.size() - a0 != 4) begin errs++; $display("FAIL basic_acks got %0d want 4", adr_q.size() - a0); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      ga = (a0 + i < adr_q.size()) ? adr_q[a0 + i] : 32'hxxxx_xxxx;
      gc = (a0 + i < cti_q.size()) ? cti_q[a0 + i] : 3'bxxx;
      gd = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hxxxx_xxxx;
      vec++; if (ga !== 32'h100 + 32'(4 * i)) begin errs++; $display("FAIL basic_adr%0d got %h want %h", i, ga, 32'h100 + 32'(4 * i)); end
      vec++; if (gc !== ((i == 3) ? 3'b111 : 3'b010)) begin errs++; $display("FAIL basic_cti%0d got %b", i, gc); end
      if (gd !== ((32'h100 + 32'(4 * i)) ^ 32'hCAFE_0000)) bad++;
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL basic_data got %0d bad words want 0", bad); end
    vec++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL basic_done got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_multi_burst;
    int a0, o0, d0, b0, bad;
    bit to;
    int got;
    logic [31:0] gd;
    out_ready = 1'b1; ack_en = 1'b1;
    a0 = adr_q.size(); o0 = out_q.size(); d0 = done_cnt; b0 = burst_q.size();
    do_start(32'h0000_2000, 16'd20);
    wait_idle(200, to);
    repeat (4) @(negedge clk);
    vec++; if (to) begin errs++; $display("FAIL multi_timeout busy still 1 want 0"); end
    vec++; if (adr_q.size() - a0 != 20) begin errs++; $display("FAIL multi_acks got %0d want 20", adr_q.size() - a0); end
    vec++; if (burst_q.size() - b0 != 3) begin errs++; $display("FAIL multi_nbursts got %0d want 3", burst_q.size() - b0); end
    for (int k = 0; k < 3; k++) begin
      got = (b0 + k < burst_q.size()) ? burst_q[b0 + k] : -1;
      vec++; if (got != ((k == 2) ? 4 : 8)) begin errs++; $display("FAIL multi_burst%0d got %0d beats want %0d", k, got, (k == 2) ? 4 : 8); end
    end
    vec++; if (adr_q[$] !== 32'h0000_204C) begin errs++; $display("FAIL multi_last_adr got %h want 0000204c", adr_q[$]); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      gd = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hxxxx_xxxx;
      if (gd !== ((32'h2000 + 32'(4 * i)) ^ 32'hCAFE_0000)) bad++;
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL multi_data got %0d bad words want 0", bad); end
    vec++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL multi_done got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure;
    int a0, o0, d0, bad;
    bit to;
    logic [31:0] gd;
    out_ready = 1'b0; ack_en = 1'b1;
    a0 = adr_q.size(); o0 = out_q.size(); d0 = done_cnt;
    do_start(32'h0000_3000, 16'd40);
    repeat (100) @(negedge clk);
    vec++; if (adr_q.size() - a0 != 16) begin errs++; $display("FAIL bp_acks_full got %0d want 16", adr_q.size() - a0); end
    vec++; if (bus.cyc !== 1'b0) begin errs++; $display("FAIL bp_cyc_stall got %b want 0", bus.cyc); end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL bp_busy got %b want 1", busy); end
    vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid got %b want 1", out_valid); end
    out_ready = 1'b1;
    wait_idle(600, to);
    repeat (20) @(negedge clk);
    vec++; if (to) begin errs++; $display("FAIL bp_timeout busy still 1 want 0"); end
    vec++; if (adr_q.size() - a0 != 40) begin errs++; $display("FAIL bp_acks got %0d want 40", adr_q.size() - a0); end
    vec++; if (out_q.size() - o0 != 40) begin errs++; $display("FAIL bp_words got %0d want 40", out_q.size() - o0); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      gd = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hxxxx_xxxx;
      if (gd !== ((32'h3000 + 32'(4 * i)) ^ 32'hCAFE_0000)) bad++;
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL bp_data got %0d bad words want 0", bad); end
    vec++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL bp_done got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_wait_states;
    int a0, o0, bad;
    bit to, found;
    logic [31:0] sa, gd, ga;
    logic [2:0] sc, gc;
    out_ready = 1'b1; ack_en = 1'b1;
    a0 = adr_q.size(); o0 = out_q.size();
    do_start(32'h0000_4000, 16'd8);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.cyc && bus.stb && bus.adr == 32'h0000_4008) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vec++; if (!found) begin errs++; $display("FAIL ws_beat3 not seen want adr 00004008"); end
    ack_en = 1'b0;
    sa = bus.adr; sc = bus.cti;
    repeat (2) begin
      @(negedge clk);
      vec++;
      if (bus.adr !== sa || bus.cti !== sc || bus.stb !== 1'b1) begin
        errs++;
        $display("FAIL ws_hold got adr %h cti %b stb %b want %h %b 1", bus.adr, bus.cti, bus.stb, sa, sc);
      end
    end
    ack_en = 1'b1;
    wait_idle(100, to);
    repeat (4) @(negedge clk);
    vec++; if (to) begin errs++; $display("FAIL ws_timeout busy still 1 want 0"); end
    vec++; if (adr_q.size() - a0 != 8) begin errs++; $display("FAIL ws_acks got %0d want 8", adr_q.size() - a0); end
    vec++; if (out_q.size() - o0 != 8) begin errs++; $display("FAIL ws_words got %0d want 8", out_q.size() - o0); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      ga = (a0 + i < adr_q.size()) ? adr_q[a0 + i] : 32'hxxxx_xxxx;
      gc = (a0 + i < cti_q.size()) ? cti_q[a0 + i] : 3'bxxx;
      gd = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hxxxx_xxxx;
      if (ga !== 32'h4000 + 32'(4 * i)) bad++;
      if (gc !== ((i == 7) ? 3'b111 : 3'b010)) bad++;
      if (gd !== ((32'h4000 + 32'(4 * i)) ^ 32'hCAFE_0000)) bad++;
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL ws_stream got %0d bad items want 0", bad); end
  endtask

  task automatic test_zero_and_ignore;
    int a0, o0, d0, r0, bad;
    bit to;
    logic [31:0] gd;
    out_ready = 1'b1; ack_en = 1'b1;
    d0 = done_cnt; r0 = cyc_rise;
    do_start(32'h0000_5000, 16'd0);
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL zero_done got %b want 1", done); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL zero_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    vec++; if (cyc_rise != r0) begin errs++; $display("FAIL zero_cyc got %0d bursts want 0", cyc_rise - r0); end
    vec++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL zero_pulses got %0d want 1", done_cnt - d0); end
    a0 = adr_q.size(); o0 = out_q.size(); d0 = done_cnt;
    do_start(32'h0000_5000, 16'd6);
    @(negedge clk);
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL ign_busy got %b want 1", busy); end
    do_start(32'h0000_9000, 16'd2);
    wait_idle(100, to);
    repeat (6) @(negedge clk);
    vec++; if (to) begin errs++; $display("FAIL ign_timeout busy still 1 want 0"); end
    vec++; if (adr_q.size() - a0 != 6) begin errs++; $display("FAIL ign_acks got %0d want 6", adr_q.size() - a0); end
    vec++; if (adr_q[$] !== 32'h0000_5014) begin errs++; $display("FAIL ign_last_adr got %h want 00005014", adr_q[$]); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      gd = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hxxxx_xxxx;
      if (gd !== ((32'h5000 + 32'(4 * i)) ^ 32'hCAFE_0000)) bad++;
    end
    vec++; if (bad != 0 || out_q.size() - o0 != 6) begin errs++; $display("FAIL ign_data got %0d bad of %0d want 0 of 6", bad, out_q.size() - o0); end
    vec++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL ign_done got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_burst;
    int a0, o0, d0, bad;
    bit to, found;
    logic [31:0] gd, ga;
    out_ready = 1'b1; ack_en = 1'b1;
    do_start(32'h0000_6000, 16'd8);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.cyc && bus.stb && bus.adr == 32'h0000_6010) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vec++; if (!found) begin errs++; $display("FAIL rst_beat5 not seen want adr 00006010"); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if (bus.cyc !== 1'b0) begin errs++; $display("FAIL rst_mid_cyc got %b want 0", bus.cyc); end
    vec++; if (bus.stb !== 1'b0) begin errs++; $display("FAIL rst_mid_stb got %b want 0", bus.stb); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    rst = 1'b0;
    @(negedge clk);
    a0 = adr_q.size(); o0 = out_q.size(); d0 = done_cnt;
    do_start(32'h0000_7000, 16'd5);
    wait_idle(100, to);
    repeat (4) @(negedge clk);
    vec++; if (to) begin errs++; $display("FAIL rst_after_timeout busy still 1 want 0"); end
    vec++; if (adr_q.size() - a0 != 5) begin errs++; $display("FAIL rst_after_acks got %0d want 5", adr_q.size() - a0); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      ga = (a0 + i < adr_q.size()) ? adr_q[a0 + i] : 32'hxxxx_xxxx;
      gd = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hxxxx_xxxx;
      if (ga !== 32'h7000 + 32'(4 * i)) bad++;
      if (gd !== ((32'h7000 + 32'(4 * i)) ^ 32'hCAFE_0000)) bad++;
    end
    vec++; if (bad != 0 || out_q.size() - o0 != 5) begin errs++; $display("FAIL rst_after_stream got %0d bad of %0d want 0 of 5", bad, out_q.size() - o0); end
    vec++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL rst_after_done got %0d pulses want 1", done_cnt - d0); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_multi_burst();
    test_backpressure();
    test_wait_states();
    test_zero_and_ignore();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
